// File: rtl/blockmem1w1r_ptrstream.sv
// Message-word source buffer: a free-running write port plus a pointer-driven
// reader that streams a programmed run of words over valid/ready.
module blockmem1w1r_ptrstream #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    input  logic                  read_ready,
    output logic                  read_last,
    output logic [ADDR_WIDTH-1:0] read_ptr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   REM_TWO  = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0]   REM_FULL = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   ptr_reg, ptr_next;
    logic [ADDR_WIDTH:0]     remaining_reg, remaining_next;
    logic                    valid_reg, valid_next;
    logic                    last_reg, last_next;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    handshake;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign handshake = valid_reg && read_ready;

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        remaining_next = remaining_reg;
        valid_next     = valid_reg;
        last_next      = last_reg;
        rd_en          = 1'b0;
        rd_addr        = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    ptr_next       = start_addr;
                    remaining_next = (length == '0) ? REM_FULL : {1'b0, length};
                    state_next     = FETCH;
                end
            end
            FETCH: begin
                rd_en      = 1'b1;
                valid_next = 1'b1;
                last_next  = (remaining_reg == REM_ONE);
                state_next = STREAM;
            end
            STREAM: begin
                if (handshake) begin
                    if (remaining_reg == REM_ONE) begin
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        // Fetch the following word on the same edge so there is no bubble.
                        ptr_next       = ptr_reg + PTR_ONE;
                        rd_addr        = ptr_reg + PTR_ONE;
                        rd_en          = 1'b1;
                        remaining_next = remaining_reg - REM_ONE;
                        last_next      = (remaining_reg == REM_TWO);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            valid_reg     <= 1'b0;
            last_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            remaining_reg <= remaining_next;
            valid_reg     <= valid_next;
            last_reg      <= last_next;
        end
    end

    // Write port stays live through reset so firmware can preload at any time.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[write_addr] <= write_data;
        end
    end

    // Registered read: a same-cycle write to rd_addr yields the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= '0;
        end else if (rd_en) begin
            data_reg <= mem[rd_addr];
        end
    end

    assign busy       = (state_reg != IDLE);
    assign read_data  = data_reg;
    assign read_valid = valid_reg;
    assign read_last  = last_reg;
    assign read_ptr   = ptr_reg;

endmodule

// File: doc/blockmem1w1r_ptrstream.md
Name: blockmem1w1r_ptrstream

Overview:
- Message-word source buffer, the read-side counterpart to the pointer-write block memories used in the hash cores.
- Firmware or the host interface writes 32-bit words into the memory at explicit addresses.
- A pointer-driven reader streams a programmed run of words to a downstream core over a valid/ready handshake.
- One word per cycle when the consumer is ready; the read pointer wraps at the end of the memory.

Parameters:
- ADDR_WIDTH, 8, memory address width; depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous active-high reset.
wr  input  1  write strobe; writes write_data to mem[write_addr].
write_addr  input  ADDR_WIDTH  write address.
write_data  input  DATA_WIDTH  write data.
start  input  1  single-cycle pulse; launches a stream. Ignored while busy.
start_addr  input  ADDR_WIDTH  first address of the stream, sampled with start.
length  input  ADDR_WIDTH  word count sampled with start; 0 means 2**ADDR_WIDTH words.
busy  output  1  high from the cycle after an accepted start until the cycle after the last handshake.
read_data  output  DATA_WIDTH  streamed word.
read_valid  output  1  read_data is valid.
read_ready  input  1  consumer accepts the word when read_valid && read_ready.
read_last  output  1  high together with read_valid on the final word.
read_ptr  output  ADDR_WIDTH  address of the word currently presented, or of the next fetch.

Behaviour:
- Reset:
  - state=IDLE; busy=0, read_valid=0, read_last=0, read_data=0, read_ptr=0, remaining count=0.
  - Memory contents are not cleared.
- Memory:
  - 2**ADDR_WIDTH x DATA_WIDTH array with a registered read; data appears one cycle after the address.
  - The write port is always active, including during reset.
- States: IDLE, FETCH, STREAM.
- IDLE:
  - start=1 loads read_ptr<=start_addr and remaining<=length (0 loads 2**ADDR_WIDTH).
  - Next state FETCH; busy=1 from the next cycle.
- FETCH (one cycle):
  - Registers mem[read_ptr] into read_data.
  - Next cycle: read_valid=1, and read_last=(remaining==1).
  - Next state STREAM.
- STREAM:
  - On read_valid && read_ready with remaining>1:
    - read_ptr<=read_ptr+1, wrapping modulo 2**ADDR_WIDTH; remaining<=remaining-1.
    - The read register loads mem[read_ptr+1] in the same edge, so read_valid stays 1 with no bubble.
    - read_last updates to (remaining-1==1).
  - On read_valid && read_ready with remaining==1:
    - Next cycle read_valid=0, read_last=0, busy=0, state IDLE.
    - read_data and read_ptr hold their last values.
  - Stall (read_valid && !read_ready): read_data, read_last and read_ptr are held stable.
  - The read register is enabled only in FETCH and on a handshake.
- Latency: start at cycle T -> first read_valid at T+2. N words with read_ready held high finish at T+1+N.
- Read/write collision:
  - A write to the address being fetched in the same cycle returns the old data (read-before-write).
  - A write to the presented address during a stall does not alter read_data.
- start while busy is ignored; there is no abort port.
- reset mid-stream: at the next edge read_valid=0, busy=0, read_ptr=0, state IDLE. The in-flight word is discarded.
- Width rules: remaining is ADDR_WIDTH+1 bits; pointer arithmetic is ADDR_WIDTH bits with natural wrap.

Test Plan:
1. Write mem[i]=32'hA000_0000+i for i=0..15; start, start_addr=0, length=16, read_ready=1 -> words A0000000..A000000F on 16 consecutive cycles starting T+2; read_last only on A000000F; busy falls at T+18.
2. start_addr=8'hFE, length=4, mem[FE]=1, mem[FF]=2, mem[00]=3, mem[01]=4 -> output 1,2,3,4; read_ptr sequence FE,FF,00,01.
3. Stream of 3 words with read_ready toggled 1,0,0,1,1 -> each word held stable during stall cycles; exactly 3 handshakes; no duplicates or drops.
4. length=0, start_addr=0x10 -> exactly 256 handshakes; read_last on the word from address 0x0F.
5. In FETCH, wr to read_ptr with 32'hDEADBEEF -> first word is the old value. During a stall, wr to the presented address -> read_data unchanged. After the handshake, a restart returns DEADBEEF.
6. Assert reset for one cycle after the 2nd handshake of an 8-word stream -> read_valid=0, busy=0, read_ptr=0 next cycle. A new start streams correctly, and memory contents are preserved. start pulses issued while busy produce no effect.
